// File: rtl/alu16_rr_sched.sv
// Round-robin front end sharing one combinational ALU among NREQ requesters.
// Each op takes one accept cycle, one execute cycle, then a held response.
module alu16_rr_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int OPW   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPW-1:0]   req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [OPW-1:0]        alu_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_result,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [15:0]           ops_done
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [GW-1:0]      gnt_reg;
    logic [GW-1:0]      last_reg;
    logic [OPW-1:0]     alu_op_reg;
    logic [WIDTH-1:0]   alu_a_reg;
    logic [WIDTH-1:0]   alu_b_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic [15:0]        ops_done_reg;

    // Candidate k is the requester k+1 positions after the last winner.
    logic [GW-1:0]      cand_idx [NREQ];
    logic [NREQ-1:0]    rot_valid;
    logic               win_found;
    logic [GW-1:0]      win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign cand_idx[gi]  = GW'((32'(last_reg) + 32'(gi) + 32'd1) % NREQ);
            assign rot_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest valid candidate wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_reg == RESP) begin
            rsp_valid[gnt_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            last_reg     <= GW'(NREQ - 1);
            alu_op_reg   <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            rsp_data_reg <= '0;
            ops_done_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg  <= EXEC;
                        gnt_reg    <= win_idx;
                        alu_op_reg <= req_op[win_idx*OPW +: OPW];
                        alu_a_reg  <= req_a[win_idx*WIDTH +: WIDTH];
                        alu_b_reg  <= req_b[win_idx*WIDTH +: WIDTH];
                    end
                end
                EXEC: begin
                    state_reg    <= RESP;
                    rsp_data_reg <= alu_result;
                end
                RESP: begin
                    // Only the granted requester's ready can retire the response.
                    if (rsp_ready[gnt_reg]) begin
                        state_reg    <= IDLE;
                        last_reg     <= gnt_reg;
                        ops_done_reg <= ops_done_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_op   = alu_op_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign rsp_data = rsp_data_reg;
    assign busy     = (state_reg != IDLE);
    assign ops_done = ops_done_reg;

endmodule

// File: tb/tb_alu16_rr_sched.sv
// Bench for alu16_rr_sched: directed scenarios plus randomized traffic,
// with an arbitration checker feeding a scoreboard drained by a response monitor.
module tb_alu16_rr_sched;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int OPW   = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*OPW-1:0]   req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [OPW-1:0]        alu_op;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [WIDTH-1:0]      alu_result;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;
    logic [15:0]           ops_done;

    alu16_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    // External ALU, also used as the reference for expected results.
    function automatic logic [WIDTH-1:0] alu_model(input logic [OPW-1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            3'd5:    return ~a;
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    assign alu_result = alu_model(alu_op, alu_a, alu_b);

    // First valid requester strictly after 'last', wrapping around.
    function automatic int ref_winner(input logic [NREQ-1:0] v, input int last);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
        int               t;
    } exp_t;

    exp_t            sbq[$];
    int              gnt_log[$];
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              model_last = NREQ - 1;
    logic [15:0]     model_done = '0;
    logic [NREQ-1:0] acc_mask = '0;
    int              arb_w;
    logic [NREQ-1:0] arb_exp;
    exp_t            mon_e;
    logic [NREQ-1:0] mon_exp;
    logic            hs;
    logic            shown = 1'b0;
    int              exp_order[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Arbitration checker: predicts the grant and queues the expected response.
    always @(negedge clk) begin
        if (reset) begin
            acc_mask = '0;
        end else begin
            arb_w   = ref_winner(req_valid, model_last);
            arb_exp = '0;
            if (sbq.size() == 0 && arb_w >= 0) arb_exp[arb_w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(arb_exp));
            chk("busy", 32'(busy), 32'(sbq.size() != 0));
            acc_mask = req_ready & req_valid;
            if (arb_exp != '0) begin
                sbq.push_back('{arb_w,
                                alu_model(req_op[arb_w*OPW +: OPW],
                                          req_a[arb_w*WIDTH +: WIDTH],
                                          req_b[arb_w*WIDTH +: WIDTH]),
                                cyc});
                gnt_log.push_back(arb_w);
            end
        end
    end

    // Response monitor: compares against the scoreboard head, retires on handshake.
    always begin
        @(negedge clk);
        hs = 1'b0;
        if (!reset) begin
            chk("ops_done", 32'(ops_done), 32'(model_done));
            if (sbq.size() == 0) begin
                if (rsp_valid != '0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sbq[0];
                if (rsp_valid != '0 || (cyc - mon_e.t) >= 2) begin
                    mon_exp = '0;
                    mon_exp[mon_e.idx] = 1'b1;
                    chk("rsp_valid", 32'(rsp_valid), 32'(mon_exp));
                    chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    if (!shown) begin
                        chk("rsp_latency", 32'(cyc - mon_e.t), 32'd2);
                        shown = 1'b1;
                    end
                    if (rsp_valid == mon_exp && rsp_ready[mon_e.idx]) begin
                        hs = 1'b1;
                        $display("rsp req=%0d data=%h cycle=%0d", mon_e.idx, rsp_data, cyc);
                    end
                end
            end
        end
        @(posedge clk);
        if (reset) begin
            sbq.delete();
            model_last = NREQ - 1;
            model_done = '0;
            shown = 1'b0;
        end else if (hs) begin
            void'(sbq.pop_front());
            model_last = mon_e.idx;
            model_done = model_done + 16'd1;
            shown = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int i);
        req_op[i*OPW +: OPW]     = OPW'($urandom_range(0, 7));
        req_a[i*WIDTH +: WIDTH]  = WIDTH'($urandom);
        req_b[i*WIDTH +: WIDTH]  = WIDTH'($urandom);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = '1;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    // mode 1: everyone requests continuously; mode 2: random traffic.
    task automatic drive_update(input int mode);
        for (int i = 0; i < NREQ; i++) begin
            if (mode == 1) begin
                if (acc_mask[i]) rand_ops(i);
                req_valid[i] = 1'b1;
            end else if (req_valid[i] && !acc_mask[i]) begin
                if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end else begin
                req_valid[i] = ($urandom_range(0, 2) == 0);
                if (req_valid[i]) rand_ops(i);
            end
        end
        rsp_ready = (mode == 1) ? '1 : NREQ'($urandom);
    endtask

    initial begin
        logic [WIDTH-1:0] held_data;
        logic [NREQ-1:0]  held_valid;
        int n;

        reset = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);

        // Single requester 2, OR op
        tick();
        req_valid = 4'b0100;
        req_op[2*OPW +: OPW] = 3'b001;
        req_a[2*WIDTH +: WIDTH] = 16'h00F0;
        req_b[2*WIDTH +: WIDTH] = 16'h0F00;
        rsp_ready = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_data", 32'(rsp_data), 32'h0FF0);
        tick();
        @(negedge clk);
        chk("single_ops_done", 32'(ops_done), 32'd1);

        // Round-robin order with all requesters active
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        rsp_ready = '1;
        n = 0;
        while (gnt_log.size() < 5 && n < 60) begin
            tick();
            drive_update(1);
            n++;
        end
        req_valid = '0;
        chk("rr_count", 32'(gnt_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < gnt_log.size()) chk("rr_order", 32'(gnt_log[k]), 32'(exp_order[k]));
        end
        drain();

        // Response stall with foreign rsp_ready bits high
        tick();
        req_valid = 4'b0001;
        rand_ops(0);
        rsp_ready = 4'b1110;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 10);
        tick();
        for (int i = 1; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == '0 && n < 10);
        held_data  = rsp_data;
        held_valid = rsp_valid;
        chk("stall_seen", 32'(held_valid), 32'h1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'(held_valid));
            chk("stall_data", 32'(rsp_data), 32'(held_data));
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        tick();
        req_valid = '0;
        rsp_ready = 4'b0001;
        @(negedge clk);
        drain();

        // Reset while requester 1 is in EXEC
        tick();
        req_valid = 4'b0010;
        rand_ops(1);
        rsp_ready = '1;
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_ops_done", 32'(ops_done), 32'd0);
        tick();
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        @(negedge clk);
        chk("mid_regrant", 32'(req_ready), 32'h1);
        tick();
        drain();

        // ops_done wrap
        tick();
        force dut.ops_done_reg = 16'hFFFF;
        model_done = 16'hFFFF;
        tick();
        release dut.ops_done_reg;
        @(negedge clk);
        chk("wrap_pre", 32'(ops_done), 32'hFFFF);
        tick();
        req_valid = 4'b1000;
        rand_ops(3);
        @(negedge clk);
        tick();
        drain();
        @(negedge clk);
        chk("wrap_post", 32'(ops_done), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            drive_update(2);
        end
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
